// File: rtl/xnor_match_pkg.sv
// xnor_match_pkg: shared state encoding and width helpers for the XNOR match engine
package xnor_match_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int nbeats(int w, int c);
    return w / c;
  endfunction
  function automatic int cnt_w(int w);
    return $clog2(w) + 1;
  endfunction
  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xnor_chunk_popcount.sv
// xnor_chunk_popcount: CHUNK-bit XNOR followed by a popcount of matching, unmasked bits
module xnor_chunk_popcount
  import xnor_match_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]        a_i,
  input  logic [CHUNK-1:0]        b_i,
  input  logic [CHUNK-1:0]        mask_i,
  output logic [cnt_w(CHUNK)-1:0] cnt_o
);
  localparam int PW = cnt_w(CHUNK);
  logic [CHUNK-1:0] hit;
  assign hit = ~(a_i ^ b_i) & mask_i;
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CHUNK; i++) cnt_o = cnt_o + PW'(hit[i]);
  end
endmodule

// File: rtl/xnor_match_arbiter.sv
// xnor_match_arbiter: round-robin shared XNOR match-count engine, CHUNK bits per cycle.
// Optional XNOR_MATCH_MASK_EN adds a per-request bit mask excluded from the count.
module xnor_match_arbiter
  import xnor_match_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*WIDTH-1:0]    req_a_i,
  input  logic [NREQ*WIDTH-1:0]    req_b_i,
`ifdef XNOR_MATCH_MASK_EN
  input  logic [NREQ*WIDTH-1:0]    req_mask_i,
`endif
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [id_w(NREQ)-1:0]    rsp_id_o,
  output logic [cnt_w(WIDTH)-1:0]  rsp_count_o,
  output logic                     rsp_equal_o
);
  localparam int NB  = nbeats(WIDTH, CHUNK);
  localparam int CW  = cnt_w(WIDTH);
  localparam int PW  = cnt_w(CHUNK);
  localparam int IDW = id_w(NREQ);
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]   id_q, ptr_q, gid;
  logic [CW-1:0]    acc_q, acc_d, tot_d;
  logic [BW-1:0]    beat_q;
  logic [PW-1:0]    hit_cnt;
  logic [CHUNK-1:0] m_chunk;
  logic [NREQ-1:0]  rot;
  logic             valid_q, eq_q, found;

  // Rotate so that bit 0 is the requester currently holding top priority
  always_comb begin
    rot = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
    found = 1'b0;
    gid = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && rot[i]) begin
        found = 1'b1;
        gid = IDW'((int'(ptr_q) + i) % NREQ);
      end
  end
  assign req_ready_o = (rst_n && state_q == IDLE && found) ? NREQ'(1) << gid : '0;

  xnor_chunk_popcount #(.CHUNK(CHUNK)) u_hit (
    .a_i(a_q[CHUNK-1:0]), .b_i(b_q[CHUNK-1:0]), .mask_i(m_chunk), .cnt_o(hit_cnt)
  );
  assign acc_d = acc_q + CW'(hit_cnt);

`ifdef XNOR_MATCH_MASK_EN
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    tot_q;
  logic [PW-1:0]    msk_cnt;
  xnor_chunk_popcount #(.CHUNK(CHUNK)) u_msk (
    .a_i('0), .b_i('0), .mask_i(m_q[CHUNK-1:0]), .cnt_o(msk_cnt)
  );
  assign m_chunk = m_q[CHUNK-1:0];
  assign tot_d = tot_q + CW'(msk_cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_q   <= '0;
      tot_q <= '0;
    end else if (state_q == IDLE) begin
      m_q   <= WIDTH'(req_mask_i >> (int'(gid) * WIDTH));
      tot_q <= '0;
    end else if (state_q == RUN) begin
      m_q   <= m_q >> CHUNK;
      tot_q <= tot_d;
    end
`else
  assign m_chunk = '1;
  assign tot_d = CW'(WIDTH);
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_ready_o) begin
          a_q     <= WIDTH'(req_a_i >> (int'(gid) * WIDTH));
          b_q     <= WIDTH'(req_b_i >> (int'(gid) * WIDTH));
          id_q    <= gid;
          ptr_q   <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
          acc_q   <= '0;
          beat_q  <= '0;
          eq_q    <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q  <= acc_d;
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          beat_q <= beat_q + 1'b1;
          if (beat_q == BW'(NB - 1)) begin
            eq_q    <= (acc_d == tot_d);
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_ready_i) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign rsp_valid_o = valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_count_o = acc_q;
  assign rsp_equal_o = eq_q;
endmodule

// File: tb/tb_xnor_match_arbiter.sv
// tb_xnor_match_arbiter: scoreboard bench with a spec-level arbitration and match-count model
module tb_xnor_match_arbiter;
  localparam int NREQ = 4, WIDTH = 32, CHUNK = 8;
  localparam int NB = WIDTH / CHUNK, IDW = $clog2(NREQ), CW = $clog2(WIDTH) + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       vld, req_ready, last_tk;
  logic [WIDTH-1:0]      a[NREQ], b[NREQ], m[NREQ];
  logic [NREQ*WIDTH-1:0] pa, pb, pm;
  logic                  rsp_valid, rsp_ready, rsp_equal;
  logic [IDW-1:0]        rsp_id;
  logic [CW-1:0]         rsp_count;

  always_comb begin
    pa = '0;
    pb = '0;
    pm = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i*WIDTH +: WIDTH] = a[i];
      pb[i*WIDTH +: WIDTH] = b[i];
      pm[i*WIDTH +: WIDTH] = m[i];
    end
  end

  xnor_match_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(vld), .req_ready_o(req_ready),
    .req_a_i(pa), .req_b_i(pb),
`ifdef XNOR_MATCH_MASK_EN
    .req_mask_i(pm),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_count_o(rsp_count), .rsp_equal_o(rsp_equal)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic           eq;
    int             acc;
  } exp_t;
  exp_t q[$];

  int vectors = 0, errs = 0, cyc = 0, ptr = 0;
  bit busy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
    return '0;
  endfunction

  // Arbitration model: predicts req_ready and queues the expected result of each accept
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    exp_t e;
    er = (rst_n && !busy) ? pick(vld, ptr) : '0;
    vectors++;
    if (req_ready !== er) begin
      errs++;
      $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, er);
    end
    if (!rst_n) begin
      busy = 1'b0;
      ptr = 0;
    end else if (busy) begin
      if (rsp_valid && rsp_ready) busy = 1'b0;
    end else if (er != 0) begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
      e.id  = IDW'(g);
      e.cnt = CW'($countones(~(a[g] ^ b[g]) & m[g]));
      e.eq  = (int'(e.cnt) == $countones(m[g]));
      e.acc = cyc + 1;
      q.push_back(e);
      ptr = (g + 1) % NREQ;
      busy = 1'b1;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    bit ev;
    if (!rst_n) q.delete();
    ev = rst_n && q.size() > 0 && cyc >= q[0].acc + NB;
    vectors++;
    if (rsp_valid !== ev) begin
      errs++;
      $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, ev);
    end
    if (!rst_n) begin
      vectors++;
      if ({rsp_id, rsp_count, rsp_equal} !== '0) begin
        errs++;
        $display("FAIL reset_outputs cyc=%0d got id=%0d cnt=%0d eq=%b want 0/0/0",
                 cyc, rsp_id, rsp_count, rsp_equal);
      end
    end else if (rsp_valid && q.size() > 0) begin
      vectors++;
      if (rsp_id !== q[0].id || rsp_count !== q[0].cnt || rsp_equal !== q[0].eq) begin
        errs++;
        $display("FAIL response cyc=%0d got id=%0d cnt=%0d eq=%b want id=%0d cnt=%0d eq=%b",
                 cyc, rsp_id, rsp_count, rsp_equal, q[0].id, q[0].cnt, q[0].eq);
      end
      if (rsp_ready) void'(q.pop_front());
    end
  end

  bit reload = 1'b0, rnd = 1'b0;

  task automatic gen(int i);
    a[i] = $urandom;
    case ($urandom_range(3))
      0: b[i] = a[i];
      1: b[i] = ~a[i];
      2: b[i] = a[i] ^ (WIDTH'(1) << $urandom_range(WIDTH - 1));
      default: b[i] = $urandom;
    endcase
`ifdef XNOR_MATCH_MASK_EN
    case ($urandom_range(3))
      0: m[i] = '0;
      1: m[i] = '1;
      default: m[i] = $urandom;
    endcase
`else
    m[i] = '1;
`endif
    vld[i] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    last_tk = vld & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (last_tk[i]) begin
        if (reload) gen(i);
        else vld[i] = 1'b0;
      end
    if (rnd) begin
      for (int i = 0; i < NREQ; i++)
        if (!vld[i] && $urandom_range(2) == 0) gen(i);
        else if (vld[i] && !last_tk[i] && $urandom_range(40) == 0) vld[i] = 1'b0;
      rsp_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic issue(int i, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic [WIDTH-1:0] mk);
    a[i] = x;
    b[i] = y;
`ifdef XNOR_MATCH_MASK_EN
    m[i] = mk;
`else
    m[i] = mk | '1;
`endif
    vld[i] = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    vld = '0;
    last_tk = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
      m[i] = '1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(2, 32'hDEADBEEF, 32'hDEADBEEF, '1);
    issue(0, 32'h0000FFFF, 32'hFFFF0000, '1);
    issue(1, 32'h00000001, 32'h00000000, '1);
    // all requesters pending through reset: rotation 0,1,2,3,0...
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) gen(i);
    reload = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (28) step();
    reload = 1'b0;
    repeat (30) step();
    // backpressure in DONE
    rsp_ready = 1'b0;
    gen(3);
    repeat (16) step();
    rsp_ready = 1'b1;
    repeat (4) step();
    // reset two cycles after accept, requester 0 still pending
    reload = 1'b1;
    gen(0);
    for (int n = 0; n < 10 && !last_tk[0]; n++) step();
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    reload = 1'b0;
    repeat (8) step();
`ifdef XNOR_MATCH_MASK_EN
    issue(0, 32'h000000AA, 32'hFFFFFFAA, 32'h000000FF);
    issue(1, 32'h12345678, 32'h87654321, 32'h00000000);
`endif
    rnd = 1'b1;
    repeat (600) step();
    rnd = 1'b0;
    rsp_ready = 1'b1;
    repeat (60) step();
    vectors++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d pending responses want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/xnor_match_arbiter.md
Name: xnor_match_arbiter

Overview:
Shared bit-match engine time-multiplexed between NREQ requesters. A round-robin arbiter grants one requester at a time. The engine computes the XNOR of two WIDTH-bit operands CHUNK bits per cycle and accumulates the number of matching bits. It returns the match count and an equality flag over a valid/ready response channel. It sits between compare clients (pattern matchers, BNN-style similarity units) and is the only owner of the XNOR datapath.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 32, operand width in bits
CHUNK, 8, bits processed per cycle; WIDTH % CHUNK == 0 is required (elaboration-time check)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_id  out  $clog2(NREQ)  index of the requester served
rsp_count  out  $clog2(WIDTH)+1  number of matching bit positions
rsp_equal  out  1  1 when all counted bits match

Behaviour:
- Clock is one clock domain (clk). Reset is asynchronous, active-low (rst_n). Assertion takes effect immediately at any state; release is synchronous to clk.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_equal=0, rr pointer=0 (requester 0 has top priority), accumulator=0.
- NBEATS = WIDTH/CHUNK (default 4).
- FSM:
  - IDLE: req_ready is combinational, one-hot, for the highest-priority valid requester. Search starts at ptr and wraps modulo NREQ.
  - IDLE, on req_valid[g] & req_ready[g]: latch a/b/g, clear accumulator, set ptr=(g+1)%NREQ, go to RUN.
  - IDLE, no valid requester: stay in IDLE with req_ready=0.
  - RUN: each cycle adds popcount(~(a^b)) of the current chunk, processing LSB chunk first and shifting the operands right by CHUNK. After NBEATS cycles, go to DONE.
  - DONE: rsp_valid=1 and the outputs are held stable until rsp_ready. On handshake, go to IDLE.
- Latency: for a request accepted at edge k, rsp_valid is high from edge k+NBEATS (defaults: 4 cycles after the accept edge).
- req_ready is 0 in RUN and DONE. A new request is never accepted in the same cycle as a response handshake, so back-to-back operations have one bubble cycle in IDLE.
- Requester protocol: once req_valid is asserted, hold it and the operands stable until req_ready. Deassertion without acceptance is legal, and that requester simply loses arbitration.
- rsp_count range is 0..WIDTH. The width is sized so that WIDTH itself fits, with no wrap.
- rsp_equal = (rsp_count == number of counted bits).
- Reset mid-RUN or mid-DONE: the operation is discarded and no response is produced.
- rsp_ready held high with no rsp_valid has no effect.

Optional Feature:
XNOR_MATCH_MASK_EN
- Defined:
  - Adds port req_mask (in, NREQ*WIDTH, same packing), latched with the operands at accept.
  - Bits with mask=0 are excluded from rsp_count.
  - rsp_equal compares rsp_count against popcount(mask).
  - An all-zero mask gives rsp_count=0 and rsp_equal=1.
- Undefined: the port is absent and all WIDTH bits are counted.

Decomposition:
- Package xnor_match_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam functions for NBEATS, the count width and the id width
- One sub-module, xnor_chunk_popcount: purely combinational, CHUNK-bit XNOR followed by a popcount, with an optional mask input. The arbiter and FSM stay in the top module.

Test Plan:
- Reset then single request: req_valid[2]=1, a=b=32'hDEADBEEF -> req_ready[2] for 1 cycle; rsp_valid 4 cycles after accept; rsp_id=2, rsp_count=32, rsp_equal=1.
- Complement operands: a=32'h0000FFFF, b=32'hFFFF0000 -> rsp_count=0, rsp_equal=0. Also a=32'h1, b=32'h0 -> rsp_count=31.
- Round-robin: all four req_valid held high from reset, each with distinct operands -> grant order 0,1,2,3,0. Each response carries the matching rsp_id, and there is exactly one IDLE bubble between a response handshake and the next accept.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_id/rsp_count/rsp_equal stay stable and req_ready stays 0. Raising rsp_ready gives a handshake, then a return to IDLE.
- Reset mid-RUN: drop rst_n two cycles after accept -> outputs clear immediately and no response appears. After release, the pending req_valid[0] is granted first.
- XNOR_MATCH_MASK_EN: mask=32'h000000FF, a=32'h000000AA, b=32'hFFFFFFAA -> rsp_count=8, rsp_equal=1. Mask=0 -> rsp_count=0, rsp_equal=1.
